piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of data bits per word; legal range 2..32.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block has one clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port load_data  input  WIDTH  parallel word to serialize.
REQ-005 SHALL have port load_valid  input  1  load_data is offered.
REQ-006 SHALL have port load_ready  output  1  block accepts a word this cycle.
REQ-007 SHALL have port Data  output  1  serial bit stream, MSB first, for the downstream serial-in shift register.
REQ-008 SHALL have port Data_valid  output  1  Data carries a frame bit this cycle.
REQ-009 SHALL have port done  output  1  single-cycle pulse coincident with the last bit of a frame.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT and PARITY; PARITY exists only per REQ-024.
REQ-011 SHALL accept a word at a rising edge where load_valid=1 and load_ready=1; no other condition accepts a word.
REQ-012 SHALL drive load_ready=1 in IDLE and in the final bit cycle of a frame, and 0 otherwise; load_ready is combinational from state and counter only, not from load_valid.
REQ-013 SHALL capture load_data into an internal WIDTH-bit shift register on acceptance; later changes to load_data SHALL NOT affect the frame.
REQ-014 SHALL present load_data[WIDTH-1] on Data with Data_valid=1 in the cycle after the accepting edge (latency 1).
REQ-015 SHALL shift one bit per clock, MSB to LSB, for WIDTH consecutive cycles with Data_valid=1 throughout.
REQ-016 SHALL use a bit counter of ceil(log2(WIDTH+1)) bits, cleared on acceptance, with no wrap-around inside a frame.
REQ-017 SHALL assert done for exactly one cycle, together with the final frame bit.
REQ-018 SHALL start the next frame with no idle gap when a word is accepted in the final bit cycle (back-to-back), making Data_valid continuous.
REQ-019 SHALL, after the final bit with no acceptance, return to IDLE and drive Data=0, Data_valid=0 and done=0.
REQ-020 SHALL ignore load_valid whenever load_ready=0; there is no queueing and no error output.

Reset
REQ-021 SHALL, while rst_n=0, asynchronously force state=IDLE, counter=0, shift register=0, Data=0, Data_valid=0, done=0.
REQ-022 SHALL abort an in-progress frame on reset assertion and discard the word, with no done pulse.
REQ-023 SHALL drive load_ready=1 from the first rising edge after rst_n is deasserted.

Configuration
REQ-024 SHALL, with macro PISO_PARITY_EN defined, append one even-parity bit (XOR of the captured word) in state PARITY after the LSB, with Data_valid=1; the frame is WIDTH+1 bits, and done and load_ready move to the parity cycle.
REQ-025 SHALL, without PISO_PARITY_EN, omit the PARITY state and parity logic, making the frame WIDTH bits.

Verification
REQ-026 SHALL cover single word: WIDTH=3, load 3'b101 at t0 -> Data 1,0,1 in cycles t0+1..t0+3, done at t0+3, then IDLE with Data=0.
REQ-027 SHALL cover back-to-back: WIDTH=3, 3'b100 then 3'b011 held valid -> Data 1,0,0,0,1,1 with Data_valid high for 6 cycles and done at cycles 3 and 6.
REQ-028 SHALL cover backpressure: load_valid held high mid-frame with changed load_data -> ignored until the final bit, and the frame bits are unchanged.
REQ-029 SHALL cover reset mid-frame: WIDTH=8, 8'hA5, rst_n low after 4 bits -> Data, Data_valid and done go 0 immediately, load_ready=1 after release, and no done pulse.
REQ-030 SHALL cover parity, with PISO_PARITY_EN and WIDTH=8: load 8'h07 -> 0,0,0,0,0,1,1,1 then 1, with done on the 9th bit.
REQ-031 SHALL cover the chain check: WIDTH=3 driving a downstream 3-bit serial-in shift register, word 3'b110 -> downstream parallel output reads 3'b110 one cycle after done.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out word serializer, MSB first.
// A word is accepted on load_valid & load_ready. It is shifted out on Data,
// one bit per clock, with Data_valid high. done pulses with the last frame bit.
// A word accepted during the final bit cycle starts the next frame with no gap.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit
// (XOR of the captured word) after the LSB, giving WIDTH+1 bit frames.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             Data,
  output logic             Data_valid,
  output logic             done
);

  localparam int            CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT_IDX = CW'(WIDTH - 2);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  // Ready while idle and in the final bit cycle of a frame (back-to-back loads).
  always_comb begin
    load_ready = 1'b0;
    case (state)
      IDLE:    load_ready = 1'b1;
`ifdef PISO_PARITY_EN
      SHIFT:   load_ready = 1'b0;
      PARITY:  load_ready = 1'b1;
`else
      SHIFT:   load_ready = (cnt == LAST_IDX);
`endif
      default: load_ready = 1'b0;
    endcase
  end

  assign accept = load_valid & load_ready;

  // Frame FSM: cnt is the index of the bit currently on Data. The MSB goes
  // straight to Data on acceptance, so sreg keeps the word pre-shifted by one
  // and its top bit is always the next bit to send.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sreg       <= '0;
      Data       <= 1'b0;
      Data_valid <= 1'b0;
      done       <= 1'b0;
`ifdef PISO_PARITY_EN
      par        <= 1'b0;
`endif
    end else if (accept) begin
      state      <= SHIFT;
      cnt        <= '0;
      sreg       <= {load_data[WIDTH-2:0], 1'b0};
      Data       <= load_data[WIDTH-1];
      Data_valid <= 1'b1;
      done       <= 1'b0;
`ifdef PISO_PARITY_EN
      par        <= ^load_data;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (cnt == LAST_IDX) begin
`ifdef PISO_PARITY_EN
            state      <= PARITY;
            Data       <= par;
            Data_valid <= 1'b1;
            done       <= 1'b1;
`else
            state      <= IDLE;
            Data       <= 1'b0;
            Data_valid <= 1'b0;
            done       <= 1'b0;
`endif
          end else begin
            cnt        <= cnt + CW'(1);
            sreg       <= {sreg[WIDTH-2:0], 1'b0};
            Data       <= sreg[WIDTH-1];
            Data_valid <= 1'b1;
`ifdef PISO_PARITY_EN
            done       <= 1'b0;
`else
            done       <= (cnt == PENULT_IDX);
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          state      <= IDLE;
          Data       <= 1'b0;
          Data_valid <= 1'b0;
          done       <= 1'b0;
        end
`endif
        default: begin
          state      <= IDLE;
          Data       <= 1'b0;
          Data_valid <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed bench for piso_serializer with WIDTH=3 and
// WIDTH=8 instances. Build with PISO_PARITY_EN to check the parity frames.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int F8 = 9;
`else
  localparam int F8 = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] ld3 = '0;
  logic       lv3 = 1'b0;
  logic       rdy3, d3, v3, done3;
  logic [7:0] ld8 = '0;
  logic       lv8 = 1'b0;
  logic       rdy8, d8, v8, done8;
  logic [2:0] ds;

  int vectors = 0;
  int miscompares = 0;

  piso_serializer #(.WIDTH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .load_data(ld3), .load_valid(lv3),
    .load_ready(rdy3), .Data(d3), .Data_valid(v3), .done(done3)
  );

  piso_serializer #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .load_data(ld8), .load_valid(lv8),
    .load_ready(rdy8), .Data(d8), .Data_valid(v8), .done(done8)
  );

  always #5 clk = ~clk;

  // Downstream 3-bit serial-in shift register fed by the WIDTH=3 instance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ds <= '0;
    else if (v3) ds <= {ds[1:0], d3};
  end

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({d3, v3, done3, d8, v8, done8} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got=%b want=000000", {d3, v3, done3, d8, v8, done8});
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rdy3, rdy8, v3, v8} !== 4'b1100) begin
      miscompares++;
      $display("[TB] FAIL reset_release got=%b want=1100", {rdy3, rdy8, v3, v8});
    end
  endtask

  task automatic test_single_word;
    logic [3:0] exp [4];
    exp = '{4'b1100, 4'b0100, 4'b1111, 4'b0001};
    ld3 = 3'b101;
    lv3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({d3, v3, done3, rdy3} !== exp[i]) begin
        miscompares++;
        $display("[TB] FAIL single_c%0d got=%b want=%b", i + 1, {d3, v3, done3, rdy3}, exp[i]);
      end
      lv3 = 1'b0;
      ld3 = 3'b000;
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp [7];
    exp = '{4'b1100, 4'b0100, 4'b0111, 4'b0100, 4'b1100, 4'b1111, 4'b0001};
    ld3 = 3'b100;
    lv3 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      vectors++;
      if ({d3, v3, done3, rdy3} !== exp[i]) begin
        miscompares++;
        $display("[TB] FAIL b2b_c%0d got=%b want=%b", i + 1, {d3, v3, done3, rdy3}, exp[i]);
      end
      if (i == 0) ld3 = 3'b011;
      if (i == 3) lv3 = 1'b0;
    end
  endtask

  task automatic test_backpressure;
    logic [8:0] bits;
    logic [3:0] want;
`ifdef PISO_PARITY_EN
    bits = 9'b110000110;
`else
    bits = 9'b011000011;
`endif
    ld8 = 8'hC3;
    lv8 = 1'b1;
    for (int i = 1; i <= F8 + 1; i++) begin
      @(negedge clk);
      want = {(i <= F8) ? bits[F8 - i] : 1'b0, (i <= F8), (i == F8), (i >= F8)};
      vectors++;
      if ({d8, v8, done8, rdy8} !== want) begin
        miscompares++;
        $display("[TB] FAIL backpressure_c%0d got=%b want=%b", i, {d8, v8, done8, rdy8}, want);
      end
      if (i == 1) ld8 = 8'h3C;
      if (i == 5) lv8 = 1'b0;
    end
  endtask

  task automatic test_parity_frame;
    logic [8:0] bits;
    logic [3:0] want;
`ifdef PISO_PARITY_EN
    bits = 9'b000001111;
`else
    bits = 9'b000000111;
`endif
    ld8 = 8'h07;
    lv8 = 1'b1;
    for (int i = 1; i <= F8 + 1; i++) begin
      @(negedge clk);
      want = {(i <= F8) ? bits[F8 - i] : 1'b0, (i <= F8), (i == F8), (i >= F8)};
      vectors++;
      if ({d8, v8, done8, rdy8} !== want) begin
        miscompares++;
        $display("[TB] FAIL frame07_c%0d got=%b want=%b", i, {d8, v8, done8, rdy8}, want);
      end
      lv8 = 1'b0;
      ld8 = 8'h00;
    end
  endtask

  task automatic test_reset_midframe;
    logic [3:0] exp [4];
    exp = '{4'b1100, 4'b0100, 4'b1100, 4'b0100};
    ld8 = 8'hA5;
    lv8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({d8, v8, done8, rdy8} !== exp[i]) begin
        miscompares++;
        $display("[TB] FAIL midreset_c%0d got=%b want=%b", i + 1, {d8, v8, done8, rdy8}, exp[i]);
      end
      lv8 = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({d8, v8, done8} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL midreset_async got=%b want=000", {d8, v8, done8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if ({v8, done8, rdy8} !== 3'b001) begin
        miscompares++;
        $display("[TB] FAIL midreset_after_c%0d got=%b want=001", i, {v8, done8, rdy8});
      end
    end
  endtask

  task automatic test_chain;
    ld3 = 3'b110;
    lv3 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      lv3 = 1'b0;
    end
    vectors++;
    if (done3 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL chain_done got=%b want=1", done3);
    end
    @(negedge clk);
    vectors++;
    if (ds !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL chain_parallel got=%b want=110", ds);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_parity_frame();
    test_reset_midframe();
    test_chain();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
